// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-register definitions: stage FSM encoding, stage bundle
// typedefs used to size pipeline registers, and a small occupancy helper.
package pipe_stage_reg_pkg;

    // Stage occupancy state; the encoding doubles as the held-entry count
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // ID/EXE stage bundle; its width is what a pipe_stage_reg is built with
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_exe_bundle_t;

    localparam int ID_EXE_W = $bits(id_exe_bundle_t);

    // Number of held entries for a given state; never returns 3
    function automatic logic [1:0] occ_of(input stage_state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_data.sv
// Payload register with load enable and synchronous clear; used for both
// the main (output) entry and the skid entry of a pipeline stage.
module pipe_data_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Reset and clear both zero the entry; clear wins over a same-cycle load
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid pipeline register between two pipeline stages. The main
// entry drives out_data; the skid entry absorbs the one word that arrives
// while downstream stalls, so in_ready can come straight from a flop.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occ
);

    localparam logic CLEAR_EN = (CLEAR_ON_FLUSH != 0);

    stage_state_e      state;
    stage_state_e      state_nxt;
    logic              in_fire;
    logic              out_fire;
    logic              main_load;
    logic              skid_load;
    logic              main_from_skid;
    logic              payload_clear;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    assign in_fire       = in_valid & in_ready;
    assign out_fire      = out_valid & out_ready;
    assign payload_clear = flush & CLEAR_EN;
    assign main_d        = main_from_skid ? skid_q : in_data;

    // Next state and payload load controls; flush overrides every handshake
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_nxt = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register with the handshake outputs registered alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occ       <= 2'd0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != ST_EMPTY);
            in_ready  <= (state_nxt != ST_TWO);
            occ       <= occ_of(state_nxt);
        end
    end

    pipe_data_reg #(.DATA_W(DATA_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (payload_clear),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

    pipe_data_reg #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (payload_clear),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised bench for pipe_stage_reg: three instances cover
// the default build, the no-clear-on-flush build and a 97-bit build.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: DATA_W = 32, CLEAR_ON_FLUSH = 1
    logic        a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    // Instance B: DATA_W = 32, CLEAR_ON_FLUSH = 0
    logic        b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    // Instance C: DATA_W = 97, CLEAR_ON_FLUSH = 1
    logic        c_rst, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_flush;
    logic [96:0] c_in_data, c_out_data;
    logic [1:0]  c_occ;

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(1)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .flush(a_flush), .occ(a_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .CLEAR_ON_FLUSH(0)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .flush(b_flush), .occ(b_occ)
    );

    pipe_stage_reg #(.DATA_W(97), .CLEAR_ON_FLUSH(1)) dut_c (
        .clk(clk), .rst(c_rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .flush(c_flush), .occ(c_occ)
    );

    // Advance one clock; outputs are then stable for sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1; a_flush = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_flush = 1'b0;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b1; c_flush = 1'b0;
        step();
        step();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        checks++;
        if (a_occ !== 2'd0) begin failures++; $display("[TB] FAIL reset_occ got=%0d exp=0", a_occ); end
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", a_out_valid); end
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=1", a_in_ready); end
        checks++;
        if (a_out_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_data got=%h exp=0", a_out_data); end
        checks++;
        if (b_occ !== 2'd0 || b_out_data !== 32'h0) begin
            failures++; $display("[TB] FAIL reset_b got occ=%0d data=%h exp occ=0 data=0", b_occ, b_out_data);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = vals[i];
            step();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== vals[i]) begin
                failures++; $display("[TB] FAIL stream_data[%0d] got v=%b d=%h exp v=1 d=%h", i, a_out_valid, a_out_data, vals[i]);
            end
            checks++;
            if (a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
                failures++; $display("[TB] FAIL stream_occ[%0d] got occ=%0d rdy=%b exp occ=1 rdy=1", i, a_occ, a_in_ready);
            end
        end
        a_in_valid = 1'b0;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            failures++; $display("[TB] FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", a_out_valid, a_occ);
        end
    endtask

    task automatic test_skid_fill();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA;
        step();
        checks++;
        if (a_occ !== 2'd1 || a_out_data !== 32'hA || a_in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL skid_first got occ=%0d d=%h rdy=%b exp occ=1 d=a rdy=1", a_occ, a_out_data, a_in_ready);
        end
        a_in_data = 32'hB;
        step();
        checks++;
        if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 32'hA) begin
            failures++; $display("[TB] FAIL skid_full got occ=%0d rdy=%b d=%h exp occ=2 rdy=0 d=a", a_occ, a_in_ready, a_out_data);
        end
        a_in_data = 32'hEE;
        step();
        checks++;
        if (a_occ !== 2'd2 || a_out_data !== 32'hA) begin
            failures++; $display("[TB] FAIL skid_hold got occ=%0d d=%h exp occ=2 d=a", a_occ, a_out_data);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        step();
        checks++;
        if (a_out_data !== 32'hB || a_occ !== 2'd1 || a_in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL skid_pop1 got d=%h occ=%0d rdy=%b exp d=b occ=1 rdy=1", a_out_data, a_occ, a_in_ready);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            failures++; $display("[TB] FAIL skid_pop2 got v=%b occ=%0d exp v=0 occ=0", a_out_valid, a_occ);
        end
    endtask

    task automatic test_flush_two();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA;
        step();
        a_in_data   = 32'hB;
        step();
        checks++;
        if (a_occ !== 2'd2) begin failures++; $display("[TB] FAIL flush_pre_occ got=%0d exp=2", a_occ); end
        a_flush   = 1'b1;
        a_in_data = 32'hC;
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        checks++;
        if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_in_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_two got occ=%0d v=%b d=%h rdy=%b exp occ=0 v=0 d=0 rdy=1",
                                 a_occ, a_out_valid, a_out_data, a_in_ready);
        end
        a_out_ready = 1'b1;
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data === 32'hC) begin
            failures++; $display("[TB] FAIL flush_no_c got v=%b d=%h exp v=0 d!=c", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_no_clear_flush();
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'h55;
        step();
        b_in_valid  = 1'b0;
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 32'h55) begin
            failures++; $display("[TB] FAIL noclr_load got v=%b d=%h exp v=1 d=55", b_out_valid, b_out_data);
        end
        b_flush = 1'b1;
        step();
        b_flush = 1'b0;
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 32'h55 || b_occ !== 2'd0) begin
            failures++; $display("[TB] FAIL noclr_flush got v=%b d=%h occ=%0d exp v=0 d=55 occ=0", b_out_valid, b_out_data, b_occ);
        end
    endtask

    task automatic test_reset_mid_stall();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h77;
        step();
        a_in_data   = 32'h88;
        step();
        a_in_valid  = 1'b0;
        checks++;
        if (a_occ !== 2'd2) begin failures++; $display("[TB] FAIL rst_pre_occ got=%0d exp=2", a_occ); end
        a_rst   = 1'b1;
        a_flush = 1'b1;
        step();
        a_rst   = 1'b0;
        a_flush = 1'b0;
        checks++;
        if (a_occ !== 2'd0 || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_stall_ctl got occ=%0d rdy=%b v=%b exp occ=0 rdy=1 v=0", a_occ, a_in_ready, a_out_valid);
        end
        checks++;
        if (a_out_data !== 32'h0 || dut_a.u_skid.q !== 32'h0) begin
            failures++; $display("[TB] FAIL rst_stall_data got main=%h skid=%h exp 0 0", a_out_data, dut_a.u_skid.q);
        end
        a_out_ready = 1'b1;
        step();
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_emit got v=%b exp=0", a_out_valid); end
    endtask

    task automatic test_random_stress();
        logic [96:0]  model_q [$];
        logic [127:0] rnd;
        int           nerr;
        bit           m_ready;
        nerr = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            m_ready = (model_q.size() < 2);
            checks++;
            if (c_occ !== 2'(model_q.size()) || c_occ === 2'd3) begin
                failures++; nerr++;
                if (nerr < 10) $display("[TB] FAIL stress_occ cyc=%0d got=%0d exp=%0d", cyc, c_occ, model_q.size());
            end
            checks++;
            if (c_in_ready !== m_ready || c_out_valid !== (model_q.size() > 0)) begin
                failures++; nerr++;
                if (nerr < 10) $display("[TB] FAIL stress_hs cyc=%0d got rdy=%b v=%b exp rdy=%b v=%b",
                                        cyc, c_in_ready, c_out_valid, m_ready, model_q.size() > 0);
            end
            if (model_q.size() > 0) begin
                checks++;
                if (c_out_data !== model_q[0]) begin
                    failures++; nerr++;
                    if (nerr < 10) $display("[TB] FAIL stress_data cyc=%0d got=%h exp=%h", cyc, c_out_data, model_q[0]);
                end
            end
            rnd         = {$urandom, $urandom, $urandom, $urandom};
            c_in_data   = rnd[96:0];
            c_in_valid  = ($urandom_range(0, 99) < 70);
            c_out_ready = ($urandom_range(0, 99) < 60);
            c_flush     = ($urandom_range(0, 99) < 10);
            if (c_flush) begin
                model_q.delete();
            end else begin
                if (c_out_ready && model_q.size() > 0) void'(model_q.pop_front());
                if (c_in_valid && m_ready) model_q.push_back(c_in_data);
            end
            step();
        end
        c_in_valid = 1'b0;
        c_flush    = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush_two();
        test_no_clear_flush();
        test_reset_mid_stall();
        test_random_stress();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the payload width in bits (legal range 1..1024).
REQ-002 The block SHALL have parameter CLEAR_ON_FLUSH, default 1: 1 zeroes both payload registers on flush; 0 leaves them unchanged.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream stage offers in_data.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle; it is driven directly from a register.
REQ-007 The block SHALL have port in_data, input, DATA_W bits: the upstream payload, e.g. a packed stage bundle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data holds a live instruction.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream stage consumes out_data; deasserting it stalls the stage.
REQ-010 The block SHALL have port out_data, output, DATA_W bits: the main payload register.
REQ-011 The block SHALL have port flush, input, 1 bit: the OR of hazard clear and branch-mispredict clear; it kills every held entry.
REQ-012 The block SHALL have port occ, output, 2 bits: the number of held entries (0, 1 or 2).

Function
REQ-013 The block SHALL define an input handshake: in_fire = in_valid & in_ready.
REQ-014 The block SHALL define an output handshake: out_fire = out_valid & out_ready.
REQ-015 The block SHALL hold two entries, main and skid, and one FSM with states EMPTY, ONE (main only) and TWO (main + skid).
REQ-016 In every state, out_valid SHALL be 1 exactly in ONE and TWO, out_data SHALL equal main, and in_ready SHALL be 0 exactly in TWO.
REQ-017 In EMPTY, in_fire SHALL load main and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-018 In ONE, in_fire & out_fire SHALL load main with in_data and stay in ONE, giving full throughput.
REQ-019 In ONE, out_fire alone SHALL go to EMPTY; in_fire alone SHALL load skid and go to TWO; neither SHALL hold.
REQ-020 In TWO, out_fire SHALL move skid to main and go to ONE; otherwise all state SHALL be held, and in_data SHALL be ignored because in_ready = 0.
REQ-021 Latency: data accepted into EMPTY or ONE (with out_fire) SHALL appear on out_data in the next cycle.
REQ-022 Ordering SHALL be strictly FIFO; no entry is dropped or duplicated unless flush or rst is asserted.
REQ-023 flush SHALL take priority over all handshakes: next state EMPTY and occ = 0, and in_ready = 1 in the next cycle.
REQ-024 During a flush cycle, an in_fire SHALL be discarded, and an out_fire still counts as consumed by the downstream stage.
REQ-025 On flush with CLEAR_ON_FLUSH = 1, main and skid SHALL become all-zero, so the flushed state is a NOP bubble.
REQ-026 occ SHALL equal 0, 1 or 2 in EMPTY, ONE or TWO respectively, and the encoding 3 SHALL never occur.
REQ-027 The block SHALL be functionally correct with out_ready held at 1 permanently, in which case it behaves as a plain one-cycle pipeline register.

Reset
REQ-028 rst SHALL be sampled only at the clk edge, with priority over flush and over the handshakes.
REQ-029 After rst, the state SHALL be EMPTY, with out_valid = 0, in_ready = 1, occ = 0, and main = skid = 0, regardless of CLEAR_ON_FLUSH.
REQ-030 An rst asserted in TWO (or mid-stall) SHALL discard both entries without emitting either.

Structure
REQ-031 The FSM state encoding (EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2) SHALL be placed in the shared pipeline-register header alongside the stage bundle typedefs.
REQ-032 The stage bundle typedefs SHALL supply DATA_W at instantiation, e.g. DATA_W = $bits of the ID/EXE bundle.
REQ-033 The block SHALL contain exactly one sub-module, pipe_data_reg: a DATA_W-wide register with load enable and synchronous clear, instantiated twice (main, skid).
REQ-034 The block SHALL contain no combinational path from in_valid or in_data to out_valid or out_data, and none from out_ready to in_ready.

Verification
REQ-035 The bench SHALL cover streaming: DATA_W = 32, out_ready = 1, push 0x11, 0x22, 0x33 on consecutive cycles -> out_data shows 0x11, 0x22, 0x33 one cycle later each, and occ never exceeds 1.
REQ-036 The bench SHALL cover skid fill: push 0xA then 0xB with out_ready = 0 -> occ = 2 and in_ready = 0; then out_ready = 1 -> 0xA then 0xB are emitted, in_ready returns to 1 after the first pop.
REQ-037 The bench SHALL cover flush in TWO: hold 0xA and 0xB, assert flush with in_valid = 1 and in_data = 0xC -> the next cycle shows occ = 0, out_valid = 0 and out_data = 0, and 0xC never appears.
REQ-038 The bench SHALL cover CLEAR_ON_FLUSH = 0: flush while 0x55 is in main -> out_valid = 0 and out_data remains 0x55.
REQ-039 The bench SHALL cover reset mid-stall: occ = 2, assert rst with flush = 1 -> the next cycle shows state EMPTY, in_ready = 1 and both payloads 0, and no output is emitted.
REQ-040 The bench SHALL cover random stress: DATA_W = 97, random in_valid, out_ready and flush at 10% -> a scoreboard sees no loss, duplication or reordering between flushes, and REQ-026 holds every cycle.
